// File: rtl/mips_avalon_arbiter.sv
// Avalon arbiter merging write-buffer drain, D-cache miss reads and I-fetch reads onto one master port.
// Define MIPS_ARB_RR_EN for IR vs WB/DR round-robin instead of fixed priority with a write-burst limiter.
module mips_avalon_arbiter #(
    parameter int MAX_WRITE_BURST = 4,
    parameter int CNT_BITS        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_write,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_writedata,
    input  logic [3:0]  wb_byteenable,
    output logic        wb_waitrequest,
    input  logic        dr_read,
    input  logic [31:0] dr_addr,
    output logic [31:0] dr_readdata,
    output logic        dr_waitrequest,
    input  logic        ir_read,
    input  logic [31:0] ir_addr,
    output logic [31:0] ir_readdata,
    output logic        ir_waitrequest,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    typedef enum logic [1:0] {IDLE, S_WR, S_DR, S_IR} state_t;

    state_t      state;
    logic [31:0] dr_data_q;
    logic [31:0] ir_data_q;
    logic        xfer_done;
    logic        dr_ok;
    logic        grant_wb;
    logic        grant_dr;
    logic        grant_ir;

    assign xfer_done = (avm_read | avm_write) & ~avm_waitrequest;
    // A miss must not overtake a buffered write, or it could read stale memory.
    assign dr_ok     = dr_read & ~wb_write;

`ifdef MIPS_ARB_RR_EN
    logic rr_last;
    logic group_req;

    // rr_last=1 means the WB/DR group was served last, so IR goes next.
    assign group_req = wb_write | dr_ok;
    assign grant_ir  = ir_read & (~group_req | rr_last);
    assign grant_wb  = wb_write & ~grant_ir;
    assign grant_dr  = dr_ok & ~grant_ir;
`else
    localparam logic [CNT_BITS-1:0] BURST_MAX = CNT_BITS'(MAX_WRITE_BURST);

    logic [CNT_BITS-1:0] burst_cnt;
    logic                ir_turn;

    assign ir_turn  = ir_read & (burst_cnt == BURST_MAX);
    assign grant_ir = ir_read & (ir_turn | ~(wb_write | dr_ok));
    assign grant_wb = wb_write & ~ir_turn;
    assign grant_dr = dr_ok & ~ir_turn;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            dr_data_q      <= '0;
            ir_data_q      <= '0;
`ifdef MIPS_ARB_RR_EN
            rr_last        <= 1'b0;
`else
            burst_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_wb) begin
                        state          <= S_WR;
                        avm_address    <= wb_addr;
                        avm_writedata  <= wb_writedata;
                        avm_byteenable <= wb_byteenable;
                        avm_write      <= 1'b1;
                    end else if (grant_dr) begin
                        state          <= S_DR;
                        avm_address    <= dr_addr;
                        avm_byteenable <= 4'b1111;
                        avm_read       <= 1'b1;
                    end else if (grant_ir) begin
                        state          <= S_IR;
                        avm_address    <= ir_addr;
                        avm_byteenable <= 4'b1111;
                        avm_read       <= 1'b1;
                    end
                end
                default: begin
                    if (xfer_done) begin
                        state     <= IDLE;
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        if (state == S_DR) dr_data_q <= avm_readdata;
                        if (state == S_IR) ir_data_q <= avm_readdata;
                    end
                end
            endcase
`ifdef MIPS_ARB_RR_EN
            if (state == IDLE && (grant_wb | grant_dr | grant_ir))
                rr_last <= ~grant_ir;
`else
            if (!ir_read || (state == IDLE && grant_ir))
                burst_cnt <= '0;
            else if (state == IDLE && grant_wb)
                burst_cnt <= burst_cnt + CNT_BITS'(1);
`endif
        end
    end

    assign wb_waitrequest = !(state == S_WR && xfer_done);
    assign dr_waitrequest = !(state == S_DR && xfer_done);
    assign ir_waitrequest = !(state == S_IR && xfer_done);
    assign dr_readdata    = (state == S_DR && xfer_done) ? avm_readdata : dr_data_q;
    assign ir_readdata    = (state == S_IR && xfer_done) ? avm_readdata : ir_data_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Self-checking bench for mips_avalon_arbiter: directed scenarios plus randomized requesters
// checked against a transaction-level arbitration model.
module tb_mips_avalon_arbiter;
    localparam int MAXB   = 4;
    localparam int K_NONE = 0;
    localparam int K_WB   = 1;
    localparam int K_DR   = 2;
    localparam int K_IR   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_write = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_writedata = '0;
    logic [3:0]  wb_byteenable = '0;
    logic        wb_waitrequest;
    logic        dr_read = 1'b0;
    logic [31:0] dr_addr = '0;
    logic [31:0] dr_readdata;
    logic        dr_waitrequest;
    logic        ir_read = 1'b0;
    logic [31:0] ir_addr = '0;
    logic [31:0] ir_readdata;
    logic        ir_waitrequest;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int total = 0;
    int bad   = 0;
    int wait_cfg = 0;
    bit wait_rand = 1'b0;
    int stall_cnt;
    int cur_wait;

    mips_avalon_arbiter #(.MAX_WRITE_BURST(MAXB), .CNT_BITS(3)) dut (
        .clk(clk), .rst(rst),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_writedata(wb_writedata),
        .wb_byteenable(wb_byteenable), .wb_waitrequest(wb_waitrequest),
        .dr_read(dr_read), .dr_addr(dr_addr), .dr_readdata(dr_readdata),
        .dr_waitrequest(dr_waitrequest),
        .ir_read(ir_read), .ir_addr(ir_addr), .ir_readdata(ir_readdata),
        .ir_waitrequest(ir_waitrequest),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2402_0005;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    // Memory slave: stalls each transfer for cur_wait cycles, chosen while the bus is idle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 0;
            cur_wait  <= wait_cfg;
        end else if (avm_read || avm_write) begin
            stall_cnt <= avm_waitrequest ? stall_cnt + 1 : 0;
        end else begin
            stall_cnt <= 0;
            cur_wait  <= wait_rand ? int'($urandom_range(0, 2)) : wait_cfg;
        end
    end
    assign avm_waitrequest = (avm_read || avm_write) ? (stall_cnt < cur_wait) : 1'b1;
    assign avm_readdata    = mem_word(avm_address);

    task automatic clear_inputs();
        wb_write = 1'b0; dr_read = 1'b0; ir_read = 1'b0;
        wb_addr = '0; wb_writedata = '0; wb_byteenable = '0; dr_addr = '0; ir_addr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable} !== 70'd0) begin
            bad++; $display("[TB] FAIL reset_avm: got rd=%b wr=%b addr=%h expected all zero", avm_read, avm_write, avm_address);
        end
        total++;
        if ({wb_waitrequest, dr_waitrequest, ir_waitrequest} !== 3'b111) begin
            bad++; $display("[TB] FAIL reset_wait: got %b expected 111", {wb_waitrequest, dr_waitrequest, ir_waitrequest});
        end
        total++;
        if ({dr_readdata, ir_readdata} !== 64'd0) begin
            bad++; $display("[TB] FAIL reset_rdata: got dr=%h ir=%h expected 0", dr_readdata, ir_readdata);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({avm_read, avm_write} !== 2'b00) begin
            bad++; $display("[TB] FAIL idle_no_req: got rd/wr=%b expected 00", {avm_read, avm_write});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ir_read();
        wait_cfg = 2;
        ir_addr = 32'hBFC0_0000; ir_read = 1'b1;
        @(negedge clk);
        total++;
        if (avm_read !== 1'b0) begin
            bad++; $display("[TB] FAIL ir_latency: got avm_read=%b expected 0", avm_read);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (avm_read !== 1'b1 || avm_address !== 32'hBFC0_0000 || avm_byteenable !== 4'hF) begin
                bad++; $display("[TB] FAIL ir_strobe%0d: got rd=%b addr=%h be=%h expected 1 bfc00000 f", k, avm_read, avm_address, avm_byteenable);
            end
            total++;
            if (ir_waitrequest !== (k != 2)) begin
                bad++; $display("[TB] FAIL ir_wait%0d: got %b expected %b", k, ir_waitrequest, k != 2);
            end
        end
        total++;
        if (ir_readdata !== 32'h2402_0005) begin
            bad++; $display("[TB] FAIL ir_data: got %h expected 24020005", ir_readdata);
        end
        @(posedge clk); #1 ir_read = 1'b0;
        @(negedge clk);
        total++;
        if (avm_read !== 1'b0 || ir_waitrequest !== 1'b1 || ir_readdata !== 32'h2402_0005) begin
            bad++; $display("[TB] FAIL ir_after: got rd=%b wait=%b data=%h expected 0 1 24020005", avm_read, ir_waitrequest, ir_readdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_before_read();
        wait_cfg = 1;
        wb_addr = 32'h100; wb_writedata = 32'hDEAD_BEEF; wb_byteenable = 4'b0011; wb_write = 1'b1;
        dr_addr = 32'h100; dr_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({avm_write, avm_read, avm_address, avm_writedata, avm_byteenable} !== {2'b10, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
            bad++; $display("[TB] FAIL wb_first: got wr=%b rd=%b addr=%h data=%h be=%b expected 1 0 100 deadbeef 0011",
                            avm_write, avm_read, avm_address, avm_writedata, avm_byteenable);
        end
        @(negedge clk);
        total++;
        if ({wb_waitrequest, dr_waitrequest} !== 2'b01) begin
            bad++; $display("[TB] FAIL wb_done: got wb/dr wait=%b expected 01", {wb_waitrequest, dr_waitrequest});
        end
        @(posedge clk); #1;
        wb_addr = 32'h104; wb_writedata = 32'h1234_5678; wb_byteenable = 4'b1100;
        @(negedge clk);
        total++;
        if ({avm_read, avm_write} !== 2'b00) begin
            bad++; $display("[TB] FAIL gap_idle: got rd/wr=%b expected 00", {avm_read, avm_write});
        end
        @(negedge clk);
        total++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_address !== 32'h104) begin
            bad++; $display("[TB] FAIL dr_blocked: got wr=%b rd=%b addr=%h expected 1 0 104", avm_write, avm_read, avm_address);
        end
        @(negedge clk);
        @(posedge clk); #1 wb_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (avm_read !== 1'b1 || avm_address !== 32'h100 || avm_byteenable !== 4'hF) begin
            bad++; $display("[TB] FAIL dr_after_wb: got rd=%b addr=%h be=%h expected 1 100 f", avm_read, avm_address, avm_byteenable);
        end
        @(negedge clk);
        total++;
        if (dr_waitrequest !== 1'b0 || dr_readdata !== mem_word(32'h100)) begin
            bad++; $display("[TB] FAIL dr_data: got wait=%b data=%h expected 0 %h", dr_waitrequest, dr_readdata, mem_word(32'h100));
        end
        @(posedge clk); #1 dr_read = 1'b0;
    endtask

    task automatic test_reset_midwrite();
        wait_cfg = 1000;
        wb_addr = 32'h200; wb_writedata = 32'hCAFE_F00D; wb_byteenable = 4'hF; wb_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (avm_write !== 1'b1 || avm_waitrequest !== 1'b1) begin
            bad++; $display("[TB] FAIL midwr_start: got wr=%b stall=%b expected 1 1", avm_write, avm_waitrequest);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (avm_write !== 1'b0 || {wb_waitrequest, dr_waitrequest, ir_waitrequest} !== 3'b111) begin
            bad++; $display("[TB] FAIL midwr_async: got wr=%b waits=%b expected 0 111", avm_write, {wb_waitrequest, dr_waitrequest, ir_waitrequest});
        end
        wait_cfg = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (avm_write !== 1'b1 || avm_address !== 32'h200 || wb_waitrequest !== 1'b0) begin
            bad++; $display("[TB] FAIL midwr_reissue: got wr=%b addr=%h wait=%b expected 1 200 0", avm_write, avm_address, wb_waitrequest);
        end
        @(posedge clk); #1 wb_write = 1'b0;
    endtask

`ifndef MIPS_ARB_RR_EN
    task automatic test_burst_limit();
        int exp_q[$];
        int got_q[$];
        int stamp_q[$];
        int streak = 0;
        int n_wb = 0;
        int gaps_bad = 0;
        bit finished = 1'b0;
        bit wbf, irf, drf;
        wait_cfg = 0;
        for (int i = 0; i < 10; i++) begin
            if (streak == MAXB) begin exp_q.push_back(K_IR); streak = 0; end
            exp_q.push_back(K_WB); streak++;
        end
        exp_q.push_back(K_IR);
        wb_addr = 32'h1000; wb_writedata = 32'h0; wb_byteenable = 4'hF; wb_write = 1'b1;
        ir_addr = 32'h4000; ir_read = 1'b1;
        for (int c = 0; c < 300 && !finished; c++) begin
            @(negedge clk);
            wbf = !wb_waitrequest; irf = !ir_waitrequest; drf = !dr_waitrequest;
            if (wbf) begin got_q.push_back(K_WB); stamp_q.push_back(c); end
            if (irf) begin got_q.push_back(K_IR); stamp_q.push_back(c); end
            if (drf) begin got_q.push_back(K_DR); stamp_q.push_back(c); end
            @(posedge clk); #1;
            if (wbf) begin
                n_wb++; wb_addr += 4; wb_writedata = n_wb;
                if (n_wb == 10) wb_write = 1'b0;
            end
            if (irf && n_wb == 10) begin ir_read = 1'b0; finished = 1'b1; end
        end
        total++;
        if (!finished) begin
            bad++; $display("[TB] FAIL burst_timeout: got %0d writes expected 10 plus final IR", n_wb);
        end
        total++;
        if (got_q != exp_q) begin
            bad++; $display("[TB] FAIL burst_order: got %p expected %p", got_q, exp_q);
        end
        for (int i = 1; i < stamp_q.size(); i++)
            if (stamp_q[i] - stamp_q[i-1] != 2) gaps_bad++;
        total++;
        if (gaps_bad != 0) begin
            bad++; $display("[TB] FAIL burst_gap: got %0d spacings not 2 expected 0", gaps_bad);
        end
        clear_inputs();
    endtask
`else
    task automatic test_round_robin();
        int got_q[$];
        int exp_q[$];
        bit wbf, irf, drf;
        wait_cfg = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? K_WB : K_IR);
        wb_addr = 32'h2000; wb_byteenable = 4'hF; wb_write = 1'b1;
        ir_addr = 32'h4000; ir_read = 1'b1; dr_addr = 32'h2000; dr_read = 1'b1;
        for (int c = 0; c < 300 && got_q.size() < 8; c++) begin
            @(negedge clk);
            wbf = !wb_waitrequest; irf = !ir_waitrequest; drf = !dr_waitrequest;
            if (wbf) got_q.push_back(K_WB);
            if (irf) got_q.push_back(K_IR);
            if (drf) got_q.push_back(K_DR);
            @(posedge clk); #1;
            if (wbf) wb_addr += 4;
        end
        total++;
        if (got_q != exp_q) begin
            bad++; $display("[TB] FAIL rr_order: got %p expected %p", got_q, exp_q);
        end
        clear_inputs();
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random();
        bit wb_act, dr_act, ir_act, wbf, drf, irf, stopping, exp_done;
        bit wb_go, dr_go, ir_go;
        int wb_gap, dr_gap, ir_gap;
        int m_kind, m_cnt;
        bit m_rr_group;
        logic [31:0] m_addr, m_data, m_last_dr, m_last_ir, exp_dr, exp_ir;
        logic [3:0]  m_be;
        logic [2:0]  exp_w;
        do_reset();
        wait_rand = 1'b1;
        wb_act = 0; dr_act = 0; ir_act = 0;
        wb_gap = 2; dr_gap = 1; ir_gap = 0;
        m_kind = K_NONE; m_cnt = 0; m_rr_group = 0;
        m_addr = '0; m_data = '0; m_be = '0; m_last_dr = '0; m_last_ir = '0;
        for (int c = 0; c < 3000; c++) begin
            stopping = (c >= 2400);
            if (stopping && !wb_act && !dr_act && !ir_act && m_kind == K_NONE) break;
            @(negedge clk);
            if (m_kind == K_NONE) begin
                total++;
                if ({avm_read, avm_write, wb_waitrequest, dr_waitrequest, ir_waitrequest} !== 5'b00111
                    || dr_readdata !== m_last_dr || ir_readdata !== m_last_ir) begin
                    bad++; $display("[TB] FAIL rnd_idle c=%0d: got rd=%b wr=%b waits=%b dr=%h ir=%h expected 0 0 111 %h %h", c, avm_read, avm_write,
                                    {wb_waitrequest, dr_waitrequest, ir_waitrequest}, dr_readdata, ir_readdata, m_last_dr, m_last_ir);
                end
                wb_go = wb_write; dr_go = dr_read && !wb_write; ir_go = ir_read;
`ifdef MIPS_ARB_RR_EN
                if (ir_go && (!(wb_go || dr_go) || m_rr_group)) m_kind = K_IR;
                else if (wb_go) m_kind = K_WB;
                else if (dr_go) m_kind = K_DR;
                if (m_kind != K_NONE) m_rr_group = (m_kind != K_IR);
`else
                if (ir_go && m_cnt == MAXB) begin m_kind = K_IR; m_cnt = 0; end
                else if (wb_go) begin m_kind = K_WB; m_cnt = ir_go ? m_cnt + 1 : 0; end
                else if (dr_go) m_kind = K_DR;
                else if (ir_go) begin m_kind = K_IR; m_cnt = 0; end
                if (!ir_go) m_cnt = 0;
`endif
                case (m_kind)
                    K_WB:    begin m_addr = wb_addr; m_data = wb_writedata; m_be = wb_byteenable; end
                    K_DR:    begin m_addr = dr_addr; m_be = 4'hF; end
                    K_IR:    begin m_addr = ir_addr; m_be = 4'hF; end
                    default: ;
                endcase
            end else begin
                total++;
                if ({avm_write, avm_read} !== ((m_kind == K_WB) ? 2'b10 : 2'b01) || avm_address !== m_addr
                    || avm_byteenable !== m_be || (m_kind == K_WB && avm_writedata !== m_data)) begin
                    bad++; $display("[TB] FAIL rnd_bus c=%0d: got wr=%b rd=%b addr=%h be=%h data=%h expected kind=%0d addr=%h be=%h data=%h",
                                    c, avm_write, avm_read, avm_address, avm_byteenable, avm_writedata, m_kind, m_addr, m_be, m_data);
                end
                exp_done = (stall_cnt >= cur_wait);
                exp_w = 3'b111;
                exp_dr = m_last_dr; exp_ir = m_last_ir;
                if (exp_done) begin
                    if (m_kind == K_WB) exp_w = 3'b011;
                    if (m_kind == K_DR) begin exp_w = 3'b101; exp_dr = mem_word(m_addr); end
                    if (m_kind == K_IR) begin exp_w = 3'b110; exp_ir = mem_word(m_addr); end
                end
                total++;
                if ({wb_waitrequest, dr_waitrequest, ir_waitrequest} !== exp_w || dr_readdata !== exp_dr || ir_readdata !== exp_ir) begin
                    bad++; $display("[TB] FAIL rnd_resp c=%0d: got waits=%b dr=%h ir=%h expected %b %h %h", c,
                                    {wb_waitrequest, dr_waitrequest, ir_waitrequest}, dr_readdata, ir_readdata, exp_w, exp_dr, exp_ir);
                end
                m_last_dr = exp_dr; m_last_ir = exp_ir;
`ifndef MIPS_ARB_RR_EN
                if (!ir_read) m_cnt = 0;
`endif
                if (exp_done) m_kind = K_NONE;
            end
            wbf = wb_act && !wb_waitrequest;
            drf = dr_act && !dr_waitrequest;
            irf = ir_act && !ir_waitrequest;
            @(posedge clk); #1;
            if (wbf) begin wb_act = 0; wb_gap = $urandom_range(0, 3); end
            if (!wb_act) begin
                if (wb_gap == 0 && !stopping) begin
                    wb_act = 1; wb_addr = $urandom & 32'hFFFF_FFFC; wb_writedata = $urandom;
                    wb_byteenable = 4'($urandom_range(1, 15));
                end else if (wb_gap > 0) wb_gap--;
            end
            if (drf) begin dr_act = 0; dr_gap = $urandom_range(0, 5); end
            if (!dr_act) begin
                if (dr_gap == 0 && !stopping) begin dr_act = 1; dr_addr = $urandom & 32'hFFFF_FFFC; end
                else if (dr_gap > 0) dr_gap--;
            end
            if (irf) begin ir_act = 0; ir_gap = $urandom_range(0, 3); end
            if (!ir_act) begin
                if (ir_gap == 0 && !stopping) begin ir_act = 1; ir_addr = $urandom & 32'hFFFF_FFFC; end
                else if (ir_gap > 0) ir_gap--;
            end
            wb_write = wb_act; dr_read = dr_act; ir_read = ir_act;
        end
        total++;
        if (wb_act || dr_act || ir_act || m_kind != K_NONE) begin
            bad++; $display("[TB] FAIL rnd_drain: got pending wb=%b dr=%b ir=%b kind=%0d expected none", wb_act, dr_act, ir_act, m_kind);
        end
        wait_rand = 1'b0;
        clear_inputs();
    endtask

    initial begin
        $display("[TB] starting mips_avalon_arbiter bench");
        test_reset();
        test_ir_read();
        test_write_before_read();
        test_reset_midwrite();
`ifdef MIPS_ARB_RR_EN
        test_round_robin();
`else
        test_burst_limit();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
